// File: rtl/nibble_deframer_pkg.sv
// Shared constants and FSM encoding for the nibble deframer.
package nibble_deframer_pkg;
   localparam int unsigned NIBBLES  = 6;
   localparam int unsigned SAMPLE_W = 24;
   localparam int unsigned NIB_W    = 4;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic {
      StHunt    = 1'b0,
      StCollect = 1'b1
   } state_e;
endpackage

// File: rtl/nibble_deframer_chan.sv
// One channel: nibble accumulator, sticky err2 flag and last-good hold concealment.
module nibble_deframer_chan
   import nibble_deframer_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_shift,
   input  logic                i_complete,
   input  logic [NIB_W-1:0]    i_nib,
   input  logic                i_err2,
   output logic [SAMPLE_W-1:0] o_data
);
   logic [SAMPLE_W-1:0] r_acc, r_last_good, r_data, w_acc_next;
   logic                r_bad, w_bad_next;

   always_comb begin
      w_acc_next = r_acc;
      w_bad_next = r_bad;
      if (i_start) begin
         w_acc_next = {{(SAMPLE_W-NIB_W){1'b0}}, i_nib};
         w_bad_next = i_err2;
      end else if (i_shift) begin
         w_acc_next = {r_acc[SAMPLE_W-NIB_W-1:0], i_nib};
         w_bad_next = r_bad | i_err2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc       <= '0;
         r_bad       <= 1'b0;
         r_last_good <= '0;
         r_data      <= '0;
      end else begin
         r_acc <= w_acc_next;
         r_bad <= w_bad_next;
         // A damaged sample is replaced by the most recent clean one.
         if (i_complete) begin
            if (!w_bad_next) begin
               r_data      <= w_acc_next;
               r_last_good <= w_acc_next;
            end else begin
               r_data <= r_last_good;
            end
         end
      end
   end

   assign o_data = r_data;
endmodule

// File: rtl/sat_counter.sv
// Statistics counter that adds 0..2 per cycle and sticks at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [1:0]       i_inc,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] r_count;
   logic [CNT_W:0]   w_sum;

   assign w_sum   = {1'b0, r_count} + (CNT_W+1)'(i_inc);
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (w_sum[CNT_W]) begin
         r_count <= '1;
      end else begin
         r_count <= w_sum[CNT_W-1:0];
      end
   end
endmodule

// File: rtl/nibble_deframer.sv
// Reassembles framed nibble pairs into 24-bit stereo samples with error statistics.
module nibble_deframer #(
   parameter int unsigned NIBBLES = nibble_deframer_pkg::NIBBLES,
   parameter int unsigned CNT_W   = nibble_deframer_pkg::CNT_W
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic                                  i_nib_valid,
   input  logic                                  i_sof,
   input  logic [nibble_deframer_pkg::NIB_W-1:0] i_nib_left,
   input  logic [nibble_deframer_pkg::NIB_W-1:0] i_nib_right,
   input  logic                                  i_err1_left,
   input  logic                                  i_err1_right,
   input  logic                                  i_err2_left,
   input  logic                                  i_err2_right,
   input  logic                                  i_write_ready,
   output logic                                  o_write,
   output logic [nibble_deframer_pkg::SAMPLE_W-1:0] o_writedata_left,
   output logic [nibble_deframer_pkg::SAMPLE_W-1:0] o_writedata_right,
   output logic [CNT_W-1:0]                      o_cnt_corr,
   output logic [CNT_W-1:0]                      o_cnt_uncorr,
   output logic [CNT_W-1:0]                      o_cnt_overrun,
   output logic [CNT_W-1:0]                      o_cnt_misalign
);
   import nibble_deframer_pkg::*;

   localparam int unsigned IDX_W = $clog2(NIBBLES + 1);

   state_e           r_state, w_state_next;
   logic [IDX_W-1:0] r_index, w_index_next;
   logic             r_pending;
   logic             w_accept, w_start, w_shift, w_complete, w_misalign, w_write;
   logic [1:0]       w_inc_corr, w_inc_uncorr, w_inc_overrun, w_inc_misalign;

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_accept     = 1'b0;
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_misalign   = 1'b0;
      w_complete   = 1'b0;
      if (i_nib_valid) begin
         unique case (r_state)
            StHunt: begin
               if (i_sof) begin
                  w_accept     = 1'b1;
                  w_start      = 1'b1;
                  w_index_next = IDX_W'(1);
                  w_state_next = StCollect;
               end
            end
            StCollect: begin
               w_accept = 1'b1;
               if (i_sof) begin
                  w_start      = 1'b1;
                  w_misalign   = (r_index != '0);
                  w_index_next = IDX_W'(1);
               end else begin
                  w_shift      = 1'b1;
                  w_index_next = r_index + IDX_W'(1);
               end
            end
            default: ;
         endcase
         if (w_accept && (w_index_next == IDX_W'(NIBBLES))) begin
            w_complete   = 1'b1;
            w_index_next = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= StHunt;
         r_index   <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         if (w_complete) begin
            r_pending <= 1'b1;
         end else if (w_write) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Gated by reset so no transfer is signalled before pending has been cleared.
   assign w_write = r_pending & i_write_ready & ~i_reset;
   assign o_write = w_write;

   assign w_inc_corr     = w_accept ? (2'(i_err1_left) + 2'(i_err1_right)) : 2'd0;
   assign w_inc_uncorr   = w_accept ? (2'(i_err2_left) + 2'(i_err2_right)) : 2'd0;
   assign w_inc_overrun  = {1'b0, w_complete & r_pending & ~w_write};
   assign w_inc_misalign = {1'b0, w_misalign};

   nibble_deframer_chan u_chan_left (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_start),
      .i_shift    (w_shift),
      .i_complete (w_complete),
      .i_nib      (i_nib_left),
      .i_err2     (i_err2_left),
      .o_data     (o_writedata_left)
   );

   nibble_deframer_chan u_chan_right (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_start),
      .i_shift    (w_shift),
      .i_complete (w_complete),
      .i_nib      (i_nib_right),
      .i_err2     (i_err2_right),
      .o_data     (o_writedata_right)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_corr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (w_inc_corr),
      .o_count (o_cnt_corr)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_uncorr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (w_inc_uncorr),
      .o_count (o_cnt_uncorr)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_overrun (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (w_inc_overrun),
      .o_count (o_cnt_overrun)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_misalign (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (w_inc_misalign),
      .o_count (o_cnt_misalign)
   );
endmodule

// File: tb/tb_nibble_deframer.sv
// Randomized and directed bench for nibble_deframer with a queue-based reference model.
module tb_nibble_deframer;
   localparam int unsigned NIB   = 6;
   localparam int unsigned CW    = 16;
   localparam int unsigned MAXC  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, nib_valid, sof, wr;
   logic [3:0]    nib_l, nib_r;
   logic          e1l, e1r, e2l, e2r;
   logic          write;
   logic [23:0]   wd_l, wd_r;
   logic [CW-1:0] c_corr, c_uncorr, c_over, c_mis;

   nibble_deframer #(.NIBBLES(NIB), .CNT_W(CW)) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_nib_valid       (nib_valid),
      .i_sof             (sof),
      .i_nib_left        (nib_l),
      .i_nib_right       (nib_r),
      .i_err1_left       (e1l),
      .i_err1_right      (e1r),
      .i_err2_left       (e2l),
      .i_err2_right      (e2r),
      .i_write_ready     (wr),
      .o_write           (write),
      .o_writedata_left  (wd_l),
      .o_writedata_right (wd_r),
      .o_cnt_corr        (c_corr),
      .o_cnt_uncorr      (c_uncorr),
      .o_cnt_overrun     (c_over),
      .o_cnt_misalign    (c_mis)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [23:0] l;
      logic [23:0] r;
   } exp_t;
   exp_t exp_q[$];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Reference model: a sample is just the list of nibbles received since sof.
   bit          m_sync;
   logic [3:0]  m_nl[$];
   logic [3:0]  m_nr[$];
   bit          m_badl, m_badr, m_pend;
   logic [23:0] m_lgl, m_lgr, m_sl, m_sr;
   int unsigned m_corr, m_uncorr, m_over, m_mis;

   function automatic int unsigned sat(input int unsigned x);
      return (x > MAXC) ? MAXC : x;
   endfunction

   function automatic logic [23:0] to_word(input logic [3:0] q[$]);
      logic [23:0] v = '0;
      foreach (q[i]) v = v * 16 + 24'(q[i]);
      return v;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_nl.delete(); m_nr.delete();
      m_badl = 0; m_badr = 0; m_pend = 0;
      m_lgl = '0; m_lgr = '0; m_sl = '0; m_sr = '0;
      m_corr = 0; m_uncorr = 0; m_over = 0; m_mis = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   task automatic check_cnts(input string tag);
      chk({tag, "_corr"}, 32'(c_corr), m_corr);
      chk({tag, "_uncorr"}, 32'(c_uncorr), m_uncorr);
      chk({tag, "_overrun"}, 32'(c_over), m_over);
      chk({tag, "_misalign"}, 32'(c_mis), m_mis);
   endtask

   // One clock cycle of stimulus; the model predicts this cycle's write, if any.
   task automatic step(input bit v, input bit s, input logic [3:0] nl, input logic [3:0] nr,
                       input bit a1l, input bit a1r, input bit a2l, input bit a2r, input bit r);
      bit wthis, comp;
      reset = 0; nib_valid = v; sof = s; nib_l = nl; nib_r = nr;
      e1l = a1l; e1r = a1r; e2l = a2l; e2r = a2r; wr = r;
      wthis = m_pend && r;
      comp  = 0;
      if (wthis) exp_q.push_back('{cyc, m_sl, m_sr});
      if (v && (m_sync || s)) begin
         if (s) begin
            if (m_sync && m_nl.size() != 0) m_mis = sat(m_mis + 1);
            m_nl.delete(); m_nr.delete();
            m_badl = 0; m_badr = 0; m_sync = 1;
         end
         m_nl.push_back(nl); m_nr.push_back(nr);
         m_badl = m_badl | a2l; m_badr = m_badr | a2r;
         m_corr   = sat(m_corr + a1l + a1r);
         m_uncorr = sat(m_uncorr + a2l + a2r);
         if (m_nl.size() == NIB) begin
            comp = 1;
            if (m_pend && !wthis) m_over = sat(m_over + 1);
            if (!m_badl) m_lgl = to_word(m_nl);
            if (!m_badr) m_lgr = to_word(m_nr);
            m_sl = m_lgl; m_sr = m_lgr; m_pend = 1;
            m_nl.delete(); m_nr.delete();
         end
      end
      if (wthis && !comp) m_pend = 0;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, r);
   endtask

   task automatic do_reset();
      reset = 1; nib_valid = 0; sof = 0; wr = 0;
      e1l = 0; e1r = 0; e2l = 0; e2r = 0;
      model_reset();
      @(posedge clk); #1;
      chk("write_in_reset", 32'(write), 0);
      @(posedge clk); #1;
   endtask

   task automatic sample(input logic [23:0] l, input logic [23:0] r, input int err2l_at,
                         input bit rdy);
      for (int i = 0; i < NIB; i++) begin
         logic [3:0] a, b;
         a = l[23 - 4*i -: 4];
         b = r[23 - 4*i -: 4];
         step(1, i == 0, a, b, 0, 0, i == err2l_at, 0, rdy);
      end
   endtask

   // Monitor: every DUT write is matched against the next predicted transfer.
   always @(negedge clk) begin
      if (write) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: cycle %0d got %h/%h required no write", cyc, wd_l,
                     wd_r);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.l !== wd_l || e.r !== wd_r) begin
               miscompares++;
               $display("FAIL write_data: cycle %0d got %h/%h required cycle %0d %h/%h", cyc,
                        wd_l, wd_r, e.cyc, e.l, e.r);
            end
         end
      end
   end

   initial begin
      reset = 1; nib_valid = 0; sof = 0; nib_l = 0; nib_r = 0;
      e1l = 0; e1r = 0; e2l = 0; e2r = 0; wr = 0;
      do_reset();
      chk("reset_wd_l", 32'(wd_l), 0);
      chk("reset_wd_r", 32'(wd_r), 0);
      check_cnts("reset");

      // Basic sample, then a sample whose left channel is concealed.
      sample(24'h123456, 24'hABCDEF, -1, 1);
      chk("first_write_strobe", 32'(write), 1);
      idle(1, 1);
      chk("first_wd_l", 32'(wd_l), 32'h123456);
      chk("first_wd_r", 32'(wd_r), 32'hABCDEF);
      sample(24'h789ABC, 24'h654321, 2, 1);
      idle(2, 1);
      chk("conceal_wd_l", 32'(wd_l), 32'h123456);
      chk("conceal_wd_r", 32'(wd_r), 32'h654321);
      chk("uncorr_one", 32'(c_uncorr), 1);
      check_cnts("conceal");

      // Misaligned sof after three nibbles.
      for (int i = 0; i < 3; i++) step(1, i == 0, 4'(i + 1), 4'(i + 9), 0, 0, 0, 0, 1);
      sample(24'h0FEDCB, 24'h13579B, -1, 1);
      idle(2, 1);
      chk("misalign_one", 32'(c_mis), 1);
      check_cnts("misalign");

      // Two samples with the codec stalled: only the second survives.
      sample(24'h111111, 24'h222222, -1, 0);
      idle(2, 0);
      sample(24'h333333, 24'h444444, -1, 0);
      idle(2, 0);
      chk("overrun_one", 32'(c_over), 1);
      idle(3, 1);
      chk("overrun_wd_l", 32'(wd_l), 32'h333333);
      check_cnts("overrun");

      // Corrected-error counter saturation.
      for (int i = 0; i < (1 << CW); i++)
         step(1, (i % NIB) == 0, 4'($urandom), 4'($urandom), 1, 1, 0, 0, 1);
      idle(2, 1);
      chk("corr_saturated", 32'(c_corr), MAXC);
      check_cnts("saturate");

      // Reset mid-sample, then two stray nibbles that must be ignored.
      for (int i = 0; i < 4; i++) step(1, i == 0, 4'(i), 4'(i), 0, 0, 0, 0, 1);
      do_reset();
      chk("midreset_wd_l", 32'(wd_l), 0);
      chk("midreset_wd_r", 32'(wd_r), 0);
      check_cnts("midreset");
      step(1, 0, 4'h5, 4'h6, 1, 1, 1, 1, 1);
      step(1, 0, 4'h7, 4'h8, 1, 1, 1, 1, 1);
      idle(2, 1);
      check_cnts("stray");
      sample(24'hC0FFEE, 24'hBADA55, -1, 1);
      idle(2, 1);
      chk("after_reset_wd_l", 32'(wd_l), 32'hC0FFEE);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit v, s;
         v = ($urandom_range(0, 3) != 0);
         if (!m_sync) s = ($urandom_range(0, 3) == 0);
         else if (m_nl.size() == 0) s = 1;
         else s = ($urandom_range(0, 40) == 0);
         step(v, s, 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) != 0);
         if (i % 500 == 499) check_cnts("random");
      end
      idle(4, 1);
      check_cnts("final");
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
